// File: rtl/subleq_ctrl_pkg.sv
// Shared definitions for the SUBLEQ instruction sequencer.
package subleq_ctrl_pkg;

  // Default data/address width of the core.
  localparam int DEFAULT_WORD_SIZE = 16;

  // Sequencer states: one memory transaction per state except IDLE/HALT.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_FETCH_C = 3'd3,
    ST_READ_A  = 3'd4,
    ST_READ_B  = 3'd5,
    ST_WRITE   = 3'd6,
    ST_HALT    = 3'd7
  } state_e;

endpackage

// File: rtl/subleq_alu.sv
// SUBLEQ arithmetic: wrapped two's-complement b - a and the branch flag.
module subleq_alu
  import subleq_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic [WORD_SIZE-1:0] result,
  output logic                 leq
);

  // Result wraps; the sign bit of the wrapped value decides the branch.
  always_comb begin
    result = b - a;
    leq    = result[WORD_SIZE-1] | (result == '0);
  end

endmodule

// File: rtl/subleq_ctrl.sv
// SUBLEQ sequencer: fetches A/B/C, reads mem[A]/mem[B], writes mem[B]-mem[A]
// and branches to C when the result is <= 0. Only master on the memory port.
module subleq_ctrl
  import subleq_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 run,
  input  logic [WORD_SIZE-1:0] pc_in,
  output logic                 pc_branch,
  output logic                 pc_inc,
  output logic [WORD_SIZE-1:0] pc_addr,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 halted
);

  localparam logic [WORD_SIZE-1:0] HALT_ADDR = '1;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] reg_a_q, reg_a_d;
  logic [WORD_SIZE-1:0] reg_b_q, reg_b_d;
  logic [WORD_SIZE-1:0] reg_c_q, reg_c_d;
  logic [WORD_SIZE-1:0] val_a_q, val_a_d;
  logic [WORD_SIZE-1:0] val_b_q, val_b_d;
  logic [WORD_SIZE-1:0] alu_result;
  logic                 alu_leq;

  subleq_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .a      (val_a_q),
    .b      (val_b_q),
    .result (alu_result),
    .leq    (alu_leq)
  );

  assign pc_addr = reg_c_q;
  assign halted  = (state_q == ST_HALT);

  // Memory-port decode from state and registers only, so the request
  // stays stable across wait states regardless of mem_ack.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      ST_FETCH_A, ST_FETCH_B, ST_FETCH_C: begin
        mem_req  = 1'b1;
        mem_addr = pc_in;
      end
      ST_READ_A: begin
        mem_req  = 1'b1;
        mem_addr = reg_a_q;
      end
      ST_READ_B: begin
        mem_req  = 1'b1;
        mem_addr = reg_b_q;
      end
      ST_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = reg_b_q;
        mem_wdata = alu_result;
      end
      default: ;
    endcase
  end

  // Next state, operand capture and the PC pulses (combinational with ack).
  always_comb begin
    state_d   = state_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    reg_c_d   = reg_c_q;
    val_a_d   = val_a_q;
    val_b_d   = val_b_q;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    unique case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH_A;
      ST_FETCH_A: if (mem_ack) begin
        reg_a_d = mem_rdata;
        pc_inc  = 1'b1;
        state_d = ST_FETCH_B;
      end
      ST_FETCH_B: if (mem_ack) begin
        reg_b_d = mem_rdata;
        pc_inc  = 1'b1;
        state_d = ST_FETCH_C;
      end
      ST_FETCH_C: if (mem_ack) begin
        reg_c_d = mem_rdata;
        pc_inc  = 1'b1;
        state_d = ST_READ_A;
      end
      ST_READ_A: if (mem_ack) begin
        val_a_d = mem_rdata;
        state_d = ST_READ_B;
      end
      ST_READ_B: if (mem_ack) begin
        val_b_d = mem_rdata;
        state_d = ST_WRITE;
      end
      ST_WRITE: if (mem_ack) begin
        pc_branch = alu_leq;
        if (alu_leq && (reg_c_q == HALT_ADDR)) state_d = ST_HALT;
        else if (run)                          state_d = ST_FETCH_A;
        else                                   state_d = ST_IDLE;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and operand registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q <= ST_IDLE;
      reg_a_q <= '0;
      reg_b_q <= '0;
      reg_c_q <= '0;
      val_a_q <= '0;
      val_b_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q <= state_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      reg_c_q <= reg_c_d;
      val_a_q <= val_a_d;
      val_b_q <= val_b_d;
    end
  end

endmodule
